// File: rtl/safecrack_param_fsm.sv
// Parametrised keypad safe controller.
// Detects button press edges, checks a full-length code before giving one
// verdict, counts failed attempts into a timed lockout, relocks itself after
// an idle period and lets an unlocked user reprogram the code atomically.
module safecrack_param_fsm #(
  parameter int                      BTN_W          = 4,
  parameter int                      CODE_LEN       = 3,
  parameter logic [CODE_LEN*BTN_W-1:0] DEFAULT_CODE = 12'hDD7,
  parameter int                      MAX_TRIES      = 3,
  parameter int                      LOCKOUT_CYCLES = 16,
  parameter int                      RELOCK_CYCLES  = 64,
  parameter logic [BTN_W-1:0]        PROG_KEY       = 4'b0001,
  parameter logic [BTN_W-1:0]        LOCK_KEY       = 4'b1000
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [BTN_W-1:0]                                    btn,
  output logic                                                unlocked,
  output logic                                                locked_out,
  output logic                                                prog_mode,
  output logic [((CODE_LEN > 1) ? $clog2(CODE_LEN) : 1)-1:0] digit_idx,
  output logic [$clog2(MAX_TRIES+1)-1:0]                      fail_cnt
);

  localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int FC_W    = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam bit RELOCK_EN = (RELOCK_CYCLES > 0);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(CODE_LEN - 1);
  localparam logic [FC_W-1:0]  FC_MAX      = FC_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] RELOCK_LAST = TMR_W'(RELOCK_EN ? RELOCK_CYCLES - 1 : 0);

  // State encoding bits double as the registered status outputs:
  // bit0 = unlocked, bit1 = locked_out, bit2 = prog_mode.
  typedef enum logic [2:0] {
    S_ENTRY    = 3'b000,
    S_UNLOCKED = 3'b001,
    S_LOCKOUT  = 3'b010,
    S_PROG     = 3'b101
  } state_t;

  state_t                      state;
  logic [BTN_W-1:0]            btn_q;
  logic [CODE_LEN*BTN_W-1:0]   code;
  logic [CODE_LEN*BTN_W-1:0]   staging;
  logic [CODE_LEN*BTN_W-1:0]   commit_code;
  logic                        mismatch;
  logic [TMR_W-1:0]            timer;
  logic                        press;
  logic                        last_digit;
  logic [BTN_W-1:0]            code_digit;

  assign press      = (btn != '0) && (btn_q == '0);
  assign last_digit = (digit_idx == LAST_IDX);
  assign code_digit = code[digit_idx*BTN_W +: BTN_W];

  assign unlocked   = state[0];
  assign locked_out = state[1];
  assign prog_mode  = state[2];

  // New code image: staged digits with the final digit taken straight from the press.
  always_comb begin
    commit_code = staging;
    commit_code[(CODE_LEN-1)*BTN_W +: BTN_W] = btn;
  end

  // Main controller: edge history, code store, counters and state transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_ENTRY;
      btn_q     <= '0;
      code      <= DEFAULT_CODE;
      staging   <= '0;
      mismatch  <= 1'b0;
      timer     <= '0;
      digit_idx <= '0;
      fail_cnt  <= '0;
    end else begin
      btn_q <= btn;
      case (state)
        S_ENTRY: begin
          if (press) begin
            if (last_digit) begin
              digit_idx <= '0;
              mismatch  <= 1'b0;
              if (!mismatch && (btn == code_digit)) begin
                state    <= S_UNLOCKED;
                fail_cnt <= '0;
                timer    <= '0;
              end else if (int'(fail_cnt) + 1 < MAX_TRIES) begin
                fail_cnt <= fail_cnt + FC_W'(1);
              end else begin
                fail_cnt <= FC_MAX;
                state    <= S_LOCKOUT;
                timer    <= '0;
              end
            end else begin
              mismatch  <= mismatch | (btn != code_digit);
              digit_idx <= digit_idx + IDX_W'(1);
            end
          end
        end

        S_LOCKOUT: begin
          // Presses are ignored; only the timer matters here.
          if (timer == LOCK_LAST) begin
            state     <= S_ENTRY;
            fail_cnt  <= '0;
            digit_idx <= '0;
            mismatch  <= 1'b0;
            timer     <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_UNLOCKED: begin
          // A press takes priority over a coincident timer expiry.
          if (press) begin
            timer <= '0;
            if (btn == PROG_KEY) begin
              state     <= S_PROG;
              digit_idx <= '0;
              staging   <= '0;
            end else if (btn == LOCK_KEY) begin
              state <= S_ENTRY;
            end
          end else if (RELOCK_EN && (timer == RELOCK_LAST)) begin
            state <= S_ENTRY;
            timer <= '0;
          end else if (RELOCK_EN) begin
            timer <= timer + TMR_W'(1);
          end
        end

        S_PROG: begin
          if (press) begin
            timer <= '0;
            if (last_digit) begin
              code      <= commit_code;
              staging   <= '0;
              state     <= S_ENTRY;
              digit_idx <= '0;
              fail_cnt  <= '0;
            end else begin
              staging[digit_idx*BTN_W +: BTN_W] <= btn;
              digit_idx <= digit_idx + IDX_W'(1);
            end
          end else if (RELOCK_EN && (timer == RELOCK_LAST)) begin
            // Timeout abandons the half-entered code; the stored code is untouched.
            staging   <= '0;
            state     <= S_ENTRY;
            digit_idx <= '0;
            timer     <= '0;
          end else if (RELOCK_EN) begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: begin
          state     <= S_ENTRY;
          digit_idx <= '0;
          fail_cnt  <= '0;
          mismatch  <= 1'b0;
          timer     <= '0;
          staging   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_safecrack_param_fsm.sv
// Scoreboard bench for safecrack_param_fsm: stimulus queues expected outputs
// tagged with the cycle they apply to; a monitor compares on the falling edge.
module tb_safecrack_param_fsm;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic       unlocked;
  logic       locked_out;
  logic       prog_mode;
  logic [1:0] digit_idx;
  logic [1:0] fail_cnt;

  safecrack_param_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .prog_mode  (prog_mode),
    .digit_idx  (digit_idx),
    .fail_cnt   (fail_cnt)
  );

  typedef struct packed {
    int         cyc;
    logic       u;
    logic       l;
    logic       p;
    logic [1:0] idx;
    logic [1:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    fails  = 0;
  exp_t  cur;
  string cur_name;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire every expectation that is due in the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      cur      = exp_q.pop_front();
      cur_name = name_q.pop_front();
      checks++;
      if (cur.cyc < cyc) begin
        fails++;
        $display("FAIL %s: expectation for cycle %0d was never sampled (now %0d)", cur_name, cur.cyc, cyc);
      end else if ({unlocked, locked_out, prog_mode, digit_idx, fail_cnt} !==
                   {cur.u, cur.l, cur.p, cur.idx, cur.fc}) begin
        fails++;
        $display("FAIL %s @cyc %0d: got unl=%b lck=%b prg=%b idx=%0d fc=%0d, want unl=%b lck=%b prg=%b idx=%0d fc=%0d",
                 cur_name, cyc, unlocked, locked_out, prog_mode, digit_idx, fail_cnt,
                 cur.u, cur.l, cur.p, cur.idx, cur.fc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input int c, input bit u, input bit l, input bit p,
                      input int idx, input int fc);
    exp_t e;
    e.cyc = c; e.u = u; e.l = l; e.p = p; e.idx = 2'(idx); e.fc = 2'(fc);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic expn(input string n, input bit u, input bit l, input bit p,
                      input int idx, input int fc);
    push(n, cyc, u, l, p, idx, fc);
  endtask

  task automatic press(input logic [3:0] v);
    btn = v;
    step();
  endtask

  task automatic rel();
    btn = 4'h0;
    step();
  endtask

  task automatic tap(input logic [3:0] v);
    press(v);
    rel();
  endtask

  task automatic unlock_default();
    tap(4'h7);
    tap(4'hD);
    press(4'hD);
    expn("unlock_default", 1, 0, 0, 0, 0);
    rel();
  endtask

  initial begin
    int e;
    int u;
    int p;
    rst = 1'b0;
    btn = 4'h0;
    repeat (3) step();
    expn("reset_state", 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();

    // Correct default code 7, D, D
    press(4'h7); expn("t1_digit0", 0, 0, 0, 1, 0); rel();
    press(4'hD); expn("t1_digit1", 0, 0, 0, 2, 0); rel();
    press(4'hD); expn("t1_unlock", 1, 0, 0, 0, 0); rel();
    press(4'h8); expn("t1_lock_key", 0, 0, 0, 0, 0); rel();

    // Held button counts as a single digit
    btn = 4'h7;
    step();
    expn("hold_first", 0, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) push("hold_no_repeat", cyc + k, 0, 0, 0, 1, 0);
    repeat (4) step();
    rel();
    press(4'hD); expn("hold_digit1", 0, 0, 0, 2, 0); rel();
    press(4'hD); expn("hold_unlock", 1, 0, 0, 0, 0); rel();
    tap(4'h8);

    // Wrong digit in the middle: no early reject
    press(4'h7); expn("t2_digit0", 0, 0, 0, 1, 0); rel();
    press(4'h3); expn("t2_digit1", 0, 0, 0, 2, 0); rel();
    press(4'hD); expn("t2_fail", 0, 0, 0, 0, 1); rel();

    // Two more failures reach lockout
    tap(4'h3); tap(4'h3);
    press(4'h3); expn("t3_fail2", 0, 0, 0, 0, 2); rel();
    tap(4'h1); tap(4'h1);
    press(4'h1);
    e = cyc;
    for (int k = 0; k < 16; k++) push("lockout_active", e + k, 0, 1, 0, 0, 3);
    push("lockout_release", e + 16, 0, 0, 0, 0, 0);
    rel();
    tap(4'h7); tap(4'hD); tap(4'hD);
    while (cyc < e + 17) step();
    unlock_default();
    tap(4'h8);

    // Idle auto-relock from UNLOCKED
    unlock_default();
    u = cyc - 1;
    push("relock_last_high", u + 63, 1, 0, 0, 0, 0);
    push("relock_drop", u + 64, 0, 0, 0, 0, 0);
    while (cyc < u + 65) step();

    // Non-key press postpones relock
    unlock_default();
    u = cyc - 1;
    while (cyc < u + 59) step();
    press(4'h2);
    p = cyc;
    expn("bump_press", 1, 0, 0, 0, 0);
    push("bump_old_deadline", p + 4, 1, 0, 0, 0, 0);
    push("bump_last_high", p + 63, 1, 0, 0, 0, 0);
    push("bump_drop", p + 64, 0, 0, 0, 0, 0);
    rel();
    while (cyc < p + 65) step();

    // PROG timeout discards the partial code
    unlock_default();
    press(4'h1); expn("prog_enter", 1, 0, 1, 0, 0); rel();
    press(4'hA);
    p = cyc;
    expn("prog_partial", 1, 0, 1, 1, 0);
    push("prog_last_high", p + 63, 1, 0, 1, 1, 0);
    push("prog_timeout", p + 64, 0, 0, 0, 0, 0);
    rel();
    while (cyc < p + 65) step();
    unlock_default();
    tap(4'h8);

    // Reprogram to A, B, C
    unlock_default();
    press(4'h1); expn("reprog_enter", 1, 0, 1, 0, 0); rel();
    tap(4'hA);
    press(4'hB); expn("reprog_digit1", 1, 0, 1, 2, 0); rel();
    press(4'hC); expn("reprog_commit", 0, 0, 0, 0, 0); rel();
    tap(4'h7); tap(4'hD);
    press(4'hD); expn("old_code_fails", 0, 0, 0, 0, 1); rel();
    tap(4'hA); tap(4'hB);
    press(4'hC); expn("new_code_unlocks", 1, 0, 0, 0, 0); rel();

    // Asynchronous reset mid-PROG
    press(4'h1); expn("prog_again", 1, 0, 1, 0, 0); rel();
    press(4'h5); expn("prog_mid", 1, 0, 1, 1, 0); rel();
    #2;
    rst = 1'b0;
    expn("async_reset", 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();
    unlock_default();
    tap(4'h8);

    for (int k = 0; k < 200 && exp_q.size() > 0; k++) step();
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
